// File: rtl/mux_nx1_scan.sv
// Registered N-to-1 channel selector with manual select and auto-scan modes.
// Define MUX_CH_MASK_EN to add the ch_mask port (per-channel enable for scan and manual).
module mux_nx1_scan #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DWELL  = 4
) (
`ifdef MUX_CH_MASK_EN
    input  logic [CH_NUM-1:0]        ch_mask,
`endif
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     en,
    output logic [DATA_W-1:0]        out,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    output logic                     sel_err,
    output logic                     wrap
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0]   CH_LIM     = (SEL_W + 1)'(CH_NUM);

    logic [CH_NUM-1:0] mask;
`ifdef MUX_CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    logic [DATA_W-1:0] out_q, out_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [DW_W-1:0]   dw_q, dw_d;
    logic [SEL_W-1:0]  cur, nxt;

    function automatic logic [DATA_W-1:0] chan(input logic [CH_NUM*DATA_W-1:0] d,
                                               input logic [SEL_W-1:0] idx);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < CH_NUM; k++)
            if (SEL_W'(k) == idx) r = d[k*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic ch_on(input logic [CH_NUM-1:0] m, input logic [SEL_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int unsigned k = 0; k < CH_NUM; k++)
            if (SEL_W'(k) == idx) r = m[k];
        return r;
    endfunction

    // Lowest enabled channel above c, otherwise the lowest enabled channel overall.
    function automatic logic [SEL_W-1:0] next_en(input logic [CH_NUM-1:0] m,
                                                 input logic [SEL_W-1:0] c);
        logic [SEL_W-1:0] hi, lo;
        logic             hi_f, lo_f;
        hi = '0; lo = '0; hi_f = 1'b0; lo_f = 1'b0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            if (m[k]) begin
                if (!lo_f) begin lo = SEL_W'(k); lo_f = 1'b1; end
                if (!hi_f && SEL_W'(k) > c) begin hi = SEL_W'(k); hi_f = 1'b1; end
            end
        end
        return hi_f ? hi : lo;
    endfunction

    always_comb begin
        out_d     = out_q;
        out_sel_d = out_sel_q;
        valid_d   = valid_q;
        err_d     = err_q;
        wrap_d    = 1'b0;
        ch_d      = ch_q;
        dw_d      = dw_q;
        cur       = ch_on(mask, ch_q) ? ch_q : next_en(mask, ch_q);
        nxt       = next_en(mask, cur);
        if (en) begin
            if (!mode) begin
                ch_d      = '0;
                dw_d      = '0;
                out_sel_d = sel;
                if ({1'b0, sel} >= CH_LIM) begin
                    out_d = '0; valid_d = 1'b0; err_d = 1'b1;
                end else if (!ch_on(mask, sel)) begin
                    out_d = '0; valid_d = 1'b0; err_d = 1'b0;
                end else begin
                    out_d = chan(in, sel); valid_d = 1'b1; err_d = 1'b0;
                end
            end else if (mask == '0) begin
                out_d = '0; valid_d = 1'b0; err_d = 1'b0;
            end else begin
                // A masked current channel is skipped immediately; dwell keeps counting.
                out_d     = chan(in, cur);
                out_sel_d = cur;
                valid_d   = 1'b1;
                err_d     = 1'b0;
                if (dw_q == DWELL_LAST) begin
                    dw_d   = '0;
                    ch_d   = nxt;
                    wrap_d = (nxt < cur);
                end else begin
                    dw_d = dw_q + 1'b1;
                    ch_d = cur;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            out_sel_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            ch_q      <= '0;
            dw_q      <= '0;
        end else begin
            out_q     <= out_d;
            out_sel_q <= out_sel_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            ch_q      <= ch_d;
            dw_q      <= dw_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Scoreboard bench for mux_nx1_scan: CH_NUM=4, DATA_W=4, SEL_W=3 (sel 4..7 illegal), DWELL=2.
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  out;
    logic [2:0]  out_sel;
    logic        out_valid, sel_err, wrap;

    typedef struct packed {
        logic [3:0] out;
        logic [2:0] osel;
        logic       valid;
        logic       err;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    mux_nx1_scan #(.CH_NUM(4), .DATA_W(4), .SEL_W(3), .DWELL(2)) u_dut (
        .clk(clk), .rst(rst), .in(din), .sel(sel), .mode(mode), .en(en),
        .out(out), .out_sel(out_sel), .out_valid(out_valid), .sel_err(sel_err), .wrap(wrap)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check_zero(input string name);
        checks++;
        if (out === 4'h0 && out_sel === 3'd0 && out_valid === 1'b0 && sel_err === 1'b0 && wrap === 1'b0)
            passes++;
        else
            $display("FAIL %s: got out=%h sel=%0d valid=%b err=%b wrap=%b, want all zero",
                     name, out, out_sel, out_valid, sel_err, wrap);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected result.
    task automatic drive(input logic pre_rst, input logic e, input logic m, input logic [2:0] s,
                         input logic [15:0] d, input logic [3:0] eo, input logic [2:0] es,
                         input logic ev, input logic ee, input logic ew);
        exp_t x;
        @(negedge clk);
        if (pre_rst) begin
            rst = 1'b1;
            #1 check_zero("mid_scan_reset");
            #1 rst = 1'b0;
        end
        en = e; mode = m; sel = s; din = d;
        x.out = eo; x.osel = es; x.valid = ev; x.err = ee; x.wrap = ew;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out === e.out && out_sel === e.osel && out_valid === e.valid &&
                    sel_err === e.err && wrap === e.wrap)
                    passes++;
                else
                    $display("FAIL cycle_%0d: got out=%h sel=%0d valid=%b err=%b wrap=%b, want out=%h sel=%0d valid=%b err=%b wrap=%b",
                             checks, out, out_sel, out_valid, sel_err, wrap,
                             e.out, e.osel, e.valid, e.err, e.wrap);
            end
        end
    end

    initial begin : driver
        localparam logic [15:0] D0 = 16'hDCBA;
        localparam logic [15:0] D1 = 16'hDC5A;
        int unsigned waited;

        #3 rst = 1'b1;
        #1 check_zero("async_reset_no_clock");
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //     rst en m  sel   in   out   osel v  err wrap
        drive(0, 0, 0, 3'd2, D0, 4'h0, 3'd0, 0, 0, 0);
        drive(0, 0, 0, 3'd2, D0, 4'h0, 3'd0, 0, 0, 0);
        drive(0, 1, 0, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 0, 3'd1, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 0, 3'd2, D0, 4'hC, 3'd2, 1, 0, 0);
        drive(0, 1, 0, 3'd3, D0, 4'hD, 3'd3, 1, 0, 0);
        drive(0, 1, 0, 3'd5, D0, 4'h0, 3'd5, 0, 1, 0);
        drive(0, 1, 0, 3'd1, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 0, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 0, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 0, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hC, 3'd2, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hC, 3'd2, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hD, 3'd3, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hD, 3'd3, 1, 0, 1);
        drive(0, 0, 1, 3'd0, D0, 4'hD, 3'd3, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hC, 3'd2, 1, 0, 0);
        drive(0, 1, 0, 3'd1, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hC, 3'd2, 1, 0, 0);
        drive(1, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hA, 3'd0, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D0, 4'hB, 3'd1, 1, 0, 0);
        drive(0, 1, 1, 3'd0, D1, 4'h5, 3'd1, 1, 0, 0);
        drive(0, 1, 0, 3'd3, D1, 4'hD, 3'd3, 1, 0, 0);
        drive(0, 1, 0, 3'd7, D1, 4'h0, 3'd7, 0, 1, 0);
        drive(0, 1, 0, 3'd0, D1, 4'hA, 3'd0, 1, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
